// File: rtl/serial_mult_pn.sv
// Bit-serial x parallel multiplier. The M-bit X is latched at start and the N-bit A streams in LSB first.
// The full M+N-bit product streams out LSB first, with signed or unsigned mode chosen at start.
module serial_mult_pn #(
    parameter int M = 8,
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         sgn,
    input  logic [M-1:0] x,
    input  logic         a_bit,
    input  logic         a_valid,
    output logic         a_ready,
    output logic         busy,
    output logic         p_bit,
    output logic         p_valid,
    output logic         p_last
);

    localparam int CW = $clog2(N);
    localparam int FW = $clog2(M);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [M-1:0]  x_r;
    logic          sgn_r;
    logic [M:0]    acc;
    logic [CW-1:0] cnt;
    logic [FW-1:0] fcnt;

    logic          accept_start;
    logic          take_bit;
    logic          last_a;
    logic          last_f;
    logic [M:0]    x_ext;
    logic [M:0]    pp;
    logic [M+1:0]  acc_ext;
    logic [M+1:0]  pp_ext;
    logic [M+1:0]  sum;
    logic [M:0]    acc_shr;

    // The final p_last cycle already has state IDLE. Keep busy high through it so a start there is refused.
    assign busy    = (state != IDLE) | p_last;
    assign a_ready = (state == RUN);

    assign accept_start = (state == IDLE) && start && !p_last;
    assign take_bit     = (state == RUN) && a_valid;
    assign last_a       = (cnt == CW'(N - 1));
    assign last_f       = (fcnt == FW'(M - 1));

    // The MSB of a signed A has weight -2^(N-1), so it subtracts X instead of adding it.
    assign x_ext   = {sgn_r & x_r[M-1], x_r};
    assign pp      = a_bit ? ((sgn_r && last_a) ? -x_ext : x_ext) : '0;
    assign acc_ext = {sgn_r & acc[M], acc};
    assign pp_ext  = {sgn_r & pp[M], pp};
    assign sum     = acc_ext + pp_ext;
    assign acc_shr = {sgn_r & acc[M], acc[M:1]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept_start) state_nxt = RUN;
            RUN:     if (take_bit && last_a) state_nxt = FLUSH;
            FLUSH:   if (last_f) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_r     <= '0;
            sgn_r   <= 1'b0;
            acc     <= '0;
            cnt     <= '0;
            fcnt    <= '0;
            p_bit   <= 1'b0;
            p_valid <= 1'b0;
            p_last  <= 1'b0;
        end else begin
            p_bit   <= 1'b0;
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_start) begin
                        x_r   <= x;
                        sgn_r <= sgn;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    if (a_valid) begin
                        p_bit   <= sum[0];
                        p_valid <= 1'b1;
                        acc     <= sum[M+1:1];
                        cnt     <= cnt + 1'b1;
                        if (last_a) fcnt <= '0;
                    end
                end
                FLUSH: begin
                    p_bit   <= acc[0];
                    p_valid <= 1'b1;
                    p_last  <= last_f;
                    acc     <= acc_shr;
                    fcnt    <= fcnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
